// File: rtl/mem_pkg.sv
// Shared constants for the sized data-memory stage: access encodings, fault codes,
// sequencer states and the per-access byte count.
package mem_pkg;

   localparam logic [2:0] F3_B   = 3'b000;
   localparam logic [2:0] F3_H   = 3'b001;
   localparam logic [2:0] F3_W   = 3'b010;
   localparam logic [2:0] F3_D   = 3'b011;
   localparam logic [2:0] F3_BU  = 3'b100;
   localparam logic [2:0] F3_HU  = 3'b101;
   localparam logic [2:0] F3_WU  = 3'b110;
   localparam logic [2:0] F3_BAD = 3'b111;

   localparam logic [1:0] FLT_NONE     = 2'b00;
   localparam logic [1:0] FLT_MISALIGN = 2'b01;
   localparam logic [1:0] FLT_RANGE    = 2'b10;
   localparam logic [1:0] FLT_SIZE     = 2'b11;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } state_t;

   // Zero for the reserved encoding; callers flag that as a size fault first.
   function automatic logic [3:0] size_bytes(input logic [2:0] f3);
      case (f3)
         F3_B, F3_BU: return 4'd1;
         F3_H, F3_HU: return 4'd2;
         F3_W, F3_WU: return 4'd4;
         F3_D:        return 4'd8;
         default:     return 4'd0;
      endcase
   endfunction

endpackage

// File: rtl/mem_stage_sized_if.sv
// Execute-to-memory request bus and memory-to-writeback result bus of the data-memory stage.
interface mem_stage_sized_if #(
   parameter int XLEN = 64
);
   logic            InValid;
   logic            Ready;
   logic            Stall;
   logic [XLEN-1:0] ALUResult;
   logic [XLEN-1:0] WriteData;
   logic [2:0]      Funct3;
   logic [4:0]      Rd;
   logic            MemRead;
   logic            MemWrite;
   logic            MemtoReg;
   logic            RegWrite;
   logic            BranchTaken;

   logic            OutValid;
   logic [XLEN-1:0] ReadDataOut;
   logic [XLEN-1:0] ALUResultOut;
   logic [4:0]      RdOut;
   logic            MemtoRegOut;
   logic            RegWriteOut;
   logic            BranchTakenOut;
   logic [1:0]      FaultOut;
   logic            Busy;

   modport master (
      output InValid, Stall, ALUResult, WriteData, Funct3, Rd,
             MemRead, MemWrite, MemtoReg, RegWrite, BranchTaken,
      input  Ready, OutValid, ReadDataOut, ALUResultOut, RdOut,
             MemtoRegOut, RegWriteOut, BranchTakenOut, FaultOut, Busy
   );

   modport slave (
      input  InValid, Stall, ALUResult, WriteData, Funct3, Rd,
             MemRead, MemWrite, MemtoReg, RegWrite, BranchTaken,
      output Ready, OutValid, ReadDataOut, ALUResultOut, RdOut,
             MemtoRegOut, RegWriteOut, BranchTakenOut, FaultOut, Busy
   );
endinterface

// File: rtl/mem_load_align.sv
// Load lane select: shifts the addressed bytes down to bit 0 and sign/zero extends
// according to the access size.
module mem_load_align
   import mem_pkg::*;
#(
   parameter int XLEN = 64
) (
   input  logic [XLEN-1:0]            i_word,
   input  logic [$clog2(XLEN/8)-1:0]  i_off,
   input  logic [2:0]                 i_funct3,
   output logic [XLEN-1:0]            o_data
);
   logic [XLEN-1:0] w_sh;

   assign w_sh = i_word >> {i_off, 3'b000};

   always_comb begin
      o_data = '0;
      case (i_funct3)
         F3_B:    o_data = XLEN'($signed(w_sh[7:0]));
         F3_H:    o_data = XLEN'($signed(w_sh[15:0]));
         F3_W:    o_data = XLEN'($signed(w_sh[31:0]));
         F3_D:    o_data = w_sh;
         F3_BU:   o_data = XLEN'(w_sh[7:0]);
         F3_HU:   o_data = XLEN'(w_sh[15:0]);
         F3_WU:   o_data = XLEN'(w_sh[31:0]);
         default: o_data = '0;
      endcase
   end
endmodule

// File: rtl/mem_stage_sized.sv
// Data-memory stage: sized/signed loads and byte-masked stores, fault reporting,
// a registered MEM/WB latch and a post-reset clear sweep of the data array.
//
// state    | meaning
// ST_CLEAR | writing zero to word[r_clr_cnt], Busy=1, no requests accepted
// ST_RUN   | normal operation
module mem_stage_sized
   import mem_pkg::*;
#(
   parameter int XLEN  = 64,
   parameter int DEPTH = 1024
) (
   input logic              clk,
   input logic              reset,
   mem_stage_sized_if.slave bus
);
   localparam int NB   = XLEN / 8;
   localparam int OFF  = $clog2(NB);
   localparam int IDXW = $clog2(DEPTH);
   localparam logic [XLEN-1:0] LIMIT    = XLEN'(DEPTH * NB);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

   state_t          r_state;
   logic [IDXW-1:0] r_clr_cnt;
   logic            r_busy;
   logic [XLEN-1:0] r_mem [DEPTH];

   logic            r_out_valid;
   logic [XLEN-1:0] r_rdata;
   logic [XLEN-1:0] r_alu;
   logic [4:0]      r_rd;
   logic            r_mtr;
   logic            r_regwr;
   logic            r_bt;
   logic [1:0]      r_fault;

   logic [OFF-1:0]  w_off;
   logic [IDXW-1:0] w_idx;
   logic [3:0]      w_bytes;
   logic            w_illegal;
   logic            w_misalign;
   logic            w_oor;
   logic [1:0]      w_fault;
   logic            w_ready;
   logic            w_accept;
   logic            w_store;
   logic            w_load;
   logic [XLEN-1:0] w_bmask;
   logic [XLEN-1:0] w_wdata_sh;
   logic [XLEN-1:0] w_rword;
   logic [XLEN-1:0] w_merged;
   logic [XLEN-1:0] w_ldata;

   assign w_off     = bus.ALUResult[OFF-1:0];
   assign w_idx     = bus.ALUResult[OFF +: IDXW];
   assign w_bytes   = size_bytes(bus.Funct3);
   assign w_illegal = (bus.Funct3 == F3_BAD) ||
                      ((XLEN == 32) && ((bus.Funct3 == F3_D) || (bus.Funct3 == F3_WU)));
   assign w_misalign = (4'(w_off) & (w_bytes - 4'd1)) != 4'd0;
   assign w_oor      = bus.ALUResult >= LIMIT;

   // Faults only matter for memory operations; ALU pass-through never faults.
   always_comb begin
      w_fault = FLT_NONE;
      if (bus.MemRead || bus.MemWrite) begin
         if (w_illegal)       w_fault = FLT_SIZE;
         else if (w_misalign) w_fault = FLT_MISALIGN;
         else if (w_oor)      w_fault = FLT_RANGE;
      end
   end

   assign w_ready  = !r_busy && !bus.Stall;
   assign w_accept = bus.InValid && w_ready;
   assign w_store  = w_accept && bus.MemWrite && (w_fault == FLT_NONE);
   assign w_load   = bus.MemRead && !bus.MemWrite && (w_fault == FLT_NONE);

   always_comb begin
      w_bmask = '0;
      for (int b = 0; b < NB; b++) begin
         if ((b >= int'(w_off)) && (b < int'(w_off) + int'(w_bytes)))
            w_bmask[8*b +: 8] = 8'hFF;
      end
   end

   // Read-modify-write of the whole word keeps untouched lanes intact.
   assign w_wdata_sh = bus.WriteData << {w_off, 3'b000};
   assign w_rword    = r_mem[w_idx];
   assign w_merged   = (w_rword & ~w_bmask) | (w_wdata_sh & w_bmask);

   mem_load_align #(.XLEN(XLEN)) u_load_align (
      .i_word   (w_rword),
      .i_off    (w_off),
      .i_funct3 (bus.Funct3),
      .o_data   (w_ldata)
   );

   always_ff @(posedge clk) begin
      if (r_state == ST_CLEAR) r_mem[r_clr_cnt] <= '0;
      else if (w_store)        r_mem[w_idx]     <= w_merged;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state   <= ST_CLEAR;
         r_clr_cnt <= '0;
         r_busy    <= 1'b1;
      end else begin
         case (r_state)
            ST_CLEAR: begin
               if (r_clr_cnt == LAST_IDX) begin
                  r_state <= ST_RUN;
                  r_busy  <= 1'b0;
               end else begin
                  r_clr_cnt <= r_clr_cnt + IDXW'(1);
               end
            end
            ST_RUN: r_busy <= 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out_valid <= 1'b0;
         r_rdata     <= '0;
         r_alu       <= '0;
         r_rd        <= '0;
         r_mtr       <= 1'b0;
         r_regwr     <= 1'b0;
         r_bt        <= 1'b0;
         r_fault     <= FLT_NONE;
      end else if (w_accept) begin
         r_out_valid <= 1'b1;
         r_rdata     <= w_load ? w_ldata : '0;
         r_alu       <= bus.ALUResult;
         r_rd        <= bus.Rd;
         r_mtr       <= bus.MemtoReg;
         r_regwr     <= bus.RegWrite && (w_fault == FLT_NONE);
         r_bt        <= bus.BranchTaken;
         r_fault     <= w_fault;
      end else if (!bus.Stall) begin
         r_out_valid <= 1'b0;
      end
   end

   assign bus.Ready          = w_ready;
   assign bus.Busy           = r_busy;
   assign bus.OutValid       = r_out_valid;
   assign bus.ReadDataOut    = r_rdata;
   assign bus.ALUResultOut   = r_alu;
   assign bus.RdOut          = r_rd;
   assign bus.MemtoRegOut    = r_mtr;
   assign bus.RegWriteOut    = r_regwr;
   assign bus.BranchTakenOut = r_bt;
   assign bus.FaultOut       = r_fault;
endmodule

// File: tb/tb_mem_stage_sized.sv
// Directed bench for mem_stage_sized: clear sweep timing, sized loads/stores,
// faults, stall hold and reset during the sweep.
module tb_mem_stage_sized;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   mem_stage_sized_if #(.XLEN(64)) bus ();

   mem_stage_sized #(.XLEN(64), .DEPTH(1024)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   typedef struct {
      logic        mr, mw, rw, mtr, bt;
      logic [2:0]  f3;
      logic [63:0] addr;
      logic [63:0] wdata;
      logic [63:0] exp_rdata;
      logic [1:0]  exp_flt;
      logic        exp_rw;
   } vec_t;

   vec_t vecs[$];
   int   n_checks = 0;
   int   n_fail   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic add(input logic mr, mw, rw, mtr, bt, input logic [2:0] f3,
                      input logic [63:0] addr, wdata, exp_rdata,
                      input logic [1:0] exp_flt, input logic exp_rw);
      vec_t v;
      v.mr = mr; v.mw = mw; v.rw = rw; v.mtr = mtr; v.bt = bt; v.f3 = f3;
      v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
      v.exp_flt = exp_flt; v.exp_rw = exp_rw;
      vecs.push_back(v);
   endtask

   task automatic set_req(input logic mr, mw, rw, mtr, bt, input logic [2:0] f3,
                          input logic [63:0] addr, wdata, input logic [4:0] rd);
      bus.MemRead = mr; bus.MemWrite = mw; bus.RegWrite = rw;
      bus.MemtoReg = mtr; bus.BranchTaken = bt; bus.Funct3 = f3;
      bus.ALUResult = addr; bus.WriteData = wdata; bus.Rd = rd;
   endtask

   task automatic wait_clear(input string tag);
      int cyc = 0;
      logic ready_seen = 1'b0;
      logic done = 1'b0;
      while (!done && cyc < 1100) begin
         @(posedge clk);
         cyc++;
         #1;
         if (bus.Busy) begin
            if (bus.Ready) ready_seen = 1'b1;
         end else begin
            done = 1'b1;
         end
      end
      chk({tag, " busy cycles"}, 64'(cyc), 64'd1024);
      chk({tag, " ready during clear"}, 64'(ready_seen), 64'd0);
   endtask

   task automatic chk_zero_outputs(input string tag);
      chk({tag, " OutValid"}, 64'(bus.OutValid), 64'd0);
      chk({tag, " ReadDataOut"}, bus.ReadDataOut, 64'd0);
      chk({tag, " ALUResultOut"}, bus.ALUResultOut, 64'd0);
      chk({tag, " RdOut"}, 64'(bus.RdOut), 64'd0);
      chk({tag, " ctrl"}, 64'({bus.MemtoRegOut, bus.RegWriteOut, bus.BranchTakenOut}), 64'd0);
      chk({tag, " FaultOut"}, 64'(bus.FaultOut), 64'd0);
      chk({tag, " Busy"}, 64'(bus.Busy), 64'd1);
      chk({tag, " Ready"}, 64'(bus.Ready), 64'd0);
   endtask

   localparam logic [2:0] B = 3'd0, H = 3'd1, W = 3'd2, D = 3'd3;
   localparam logic [2:0] BU = 3'd4, HU = 3'd5, WU = 3'd6, BAD = 3'd7;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b1;
      bus.InValid = 1'b0;
      bus.Stall = 1'b0;
      set_req(0, 0, 0, 0, 0, 3'd0, 64'd0, 64'd0, 5'd0);
      #1;
      chk_zero_outputs("reset0");
      repeat (3) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      wait_clear("clear0");

      //   mr mw rw mtr bt f3   addr          wdata                   exp_rdata               flt  rw
      add(1, 0, 1, 1, 0, D,   64'h1FF8, 64'h0,                  64'h0,                  2'd0, 1);
      add(0, 1, 0, 0, 0, D,   64'h10,   64'hDEADBEEFDEADBEEF,   64'h0,                  2'd0, 0);
      add(1, 0, 1, 1, 1, B,   64'h13,   64'h0,                  64'hFFFFFFFFFFFFFFDE,   2'd0, 1);
      add(1, 0, 1, 1, 0, BU,  64'h13,   64'h0,                  64'h00000000000000DE,   2'd0, 1);
      add(1, 0, 1, 1, 0, W,   64'h14,   64'h0,                  64'hFFFFFFFFDEADBEEF,   2'd0, 1);
      add(1, 0, 1, 1, 1, WU,  64'h14,   64'h0,                  64'h00000000DEADBEEF,   2'd0, 1);
      add(0, 1, 0, 0, 0, D,   64'h20,   64'h1122334455667788,   64'h0,                  2'd0, 0);
      add(0, 1, 0, 0, 1, H,   64'h22,   64'h555555555555ABCD,   64'h0,                  2'd0, 0);
      add(1, 0, 1, 1, 0, D,   64'h20,   64'h0,                  64'h11223344ABCD7788,   2'd0, 1);
      add(1, 0, 1, 1, 0, H,   64'h22,   64'h0,                  64'hFFFFFFFFFFFFABCD,   2'd0, 1);
      add(1, 0, 1, 1, 0, HU,  64'h22,   64'h0,                  64'h000000000000ABCD,   2'd0, 1);
      add(1, 0, 1, 1, 1, W,   64'h22,   64'h0,                  64'h0,                  2'd1, 0);
      add(0, 1, 1, 0, 0, D,   64'h2000, 64'hCAFEF00DCAFEF00D,   64'h0,                  2'd2, 0);
      add(1, 0, 1, 1, 0, D,   64'h0,    64'h0,                  64'h0,                  2'd0, 1);
      add(1, 0, 1, 1, 0, BAD, 64'h8,    64'h0,                  64'h0,                  2'd3, 0);
      add(0, 0, 1, 0, 1, BAD, 64'h2001, 64'h0,                  64'h0,                  2'd0, 1);
      add(1, 0, 1, 1, 0, D,   64'h2004, 64'h0,                  64'h0,                  2'd1, 0);
      add(1, 0, 1, 1, 0, D,   64'h2008, 64'h0,                  64'h0,                  2'd2, 0);
      add(1, 1, 1, 0, 0, W,   64'h30,   64'hFFFFFFFF12345678,   64'h0,                  2'd0, 1);
      add(0, 1, 0, 0, 0, B,   64'h37,   64'h00000000000000AA,   64'h0,                  2'd0, 0);
      add(1, 0, 1, 1, 0, D,   64'h30,   64'h0,                  64'hAA00000012345678,   2'd0, 1);
      add(1, 0, 1, 1, 0, B,   64'h37,   64'h0,                  64'hFFFFFFFFFFFFFFAA,   2'd0, 1);
      add(0, 0, 1, 0, 0, D,   64'h20,   64'h0,                  64'h0,                  2'd0, 1);
      add(0, 1, 1, 0, 0, BAD, 64'h30,   64'hFFFFFFFFFFFFFFFF,   64'h0,                  2'd3, 0);
      add(1, 0, 1, 1, 0, D,   64'h30,   64'h0,                  64'hAA00000012345678,   2'd0, 1);
      add(1, 0, 1, 1, 0, BAD, 64'h2001, 64'h0,                  64'h0,                  2'd3, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         set_req(vecs[i].mr, vecs[i].mw, vecs[i].rw, vecs[i].mtr, vecs[i].bt,
                 vecs[i].f3, vecs[i].addr, vecs[i].wdata, 5'(i));
         bus.InValid = 1'b1;
         @(posedge clk);
         #1;
         chk($sformatf("v%0d ReadDataOut", i), bus.ReadDataOut, vecs[i].exp_rdata);
         chk($sformatf("v%0d FaultOut", i), 64'(bus.FaultOut), 64'(vecs[i].exp_flt));
         chk($sformatf("v%0d RegWriteOut", i), 64'(bus.RegWriteOut), 64'(vecs[i].exp_rw));
         chk($sformatf("v%0d RdOut", i), 64'(bus.RdOut), 64'(i));
         chk($sformatf("v%0d OutValid", i), 64'(bus.OutValid), 64'd1);
         chk($sformatf("v%0d ALUResultOut", i), bus.ALUResultOut, vecs[i].addr);
         chk($sformatf("v%0d MemtoReg/Branch", i), 64'({bus.MemtoRegOut, bus.BranchTakenOut}),
             64'({vecs[i].mtr, vecs[i].bt}));
      end
      @(negedge clk);
      bus.InValid = 1'b0;
      @(posedge clk);
      #1;
      chk("idle OutValid", 64'(bus.OutValid), 64'd0);
      chk("idle RdOut held", 64'(bus.RdOut), 64'(vecs.size() - 1));

      @(negedge clk);
      set_req(1, 0, 1, 1, 0, D, 64'h20, 64'h0, 5'd7);
      bus.InValid = 1'b1;
      @(posedge clk);
      #1;
      chk("pre-stall RdOut", 64'(bus.RdOut), 64'd7);
      @(negedge clk);
      set_req(1, 0, 1, 1, 0, D, 64'h10, 64'h0, 5'd13);
      bus.Stall = 1'b1;
      #1;
      chk("stall Ready", 64'(bus.Ready), 64'd0);
      for (int c = 0; c < 3; c++) begin
         @(posedge clk);
         #1;
         chk($sformatf("stall%0d RdOut", c), 64'(bus.RdOut), 64'd7);
         chk($sformatf("stall%0d ReadDataOut", c), bus.ReadDataOut, 64'h11223344ABCD7788);
         chk($sformatf("stall%0d OutValid", c), 64'(bus.OutValid), 64'd1);
         chk($sformatf("stall%0d Ready", c), 64'(bus.Ready), 64'd0);
      end
      @(negedge clk);
      bus.Stall = 1'b0;
      #1;
      chk("release Ready", 64'(bus.Ready), 64'd1);
      @(posedge clk);
      #1;
      chk("release RdOut", 64'(bus.RdOut), 64'd13);
      chk("release ReadDataOut", bus.ReadDataOut, 64'hDEADBEEFDEADBEEF);
      chk("release OutValid", 64'(bus.OutValid), 64'd1);
      @(negedge clk);
      bus.InValid = 1'b0;

      reset = 1'b1;
      #1;
      chk_zero_outputs("reset1");
      @(negedge clk);
      reset = 1'b0;
      repeat (500) @(posedge clk);
      #1;
      chk("mid-sweep Busy", 64'(bus.Busy), 64'd1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk_zero_outputs("reset2");
      @(negedge clk);
      reset = 1'b0;
      wait_clear("clear2");

      @(negedge clk);
      set_req(1, 0, 1, 1, 0, D, 64'h10, 64'h0, 5'd3);
      bus.InValid = 1'b1;
      @(posedge clk);
      #1;
      chk("post-clear LD 0x10", bus.ReadDataOut, 64'h0);
      chk("post-clear LD 0x10 valid", 64'(bus.OutValid), 64'd1);
      @(negedge clk);
      set_req(1, 0, 1, 1, 0, D, 64'h30, 64'h0, 5'd4);
      @(posedge clk);
      #1;
      chk("post-clear LD 0x30", bus.ReadDataOut, 64'h0);
      @(negedge clk);
      bus.InValid = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/mem_stage_sized.md
Name: mem_stage_sized

Overview:
- Parametrised successor to the processor's data-memory stage.
- Adds RISC-V sized and signed loads/stores (B/H/W/D with zero or sign extension), byte-lane write masking, and alignment, range and size fault reporting.
- Adds a registered MEM/WB output latch with valid/stall handshake, and a post-reset memory-clear sequencer.
- Sits between the execute stage and writeback.

Parameters:
- XLEN, 64, data/address width; legal values 32 or 64.
- DEPTH, 1024, number of XLEN-bit words in the data array; power of two.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- InValid  in  1  request present from execute
- Ready  out  1  stage can accept; equals !Busy && !Stall
- Stall  in  1  writeback not accepting; holds the output latch
- ALUResult  in  XLEN  byte address, or pass-through result
- WriteData  in  XLEN  store data, low bytes used
- Funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 011 D, 100 BU, 101 HU, 110 WU
- Rd  in  5  destination register
- MemRead, MemWrite, MemtoReg, RegWrite, BranchTaken  in  1 each  control bits
- OutValid  out  1  output latch holds a valid result
- ReadDataOut  out  XLEN  extended load data
- ALUResultOut  out  XLEN  registered ALUResult
- RdOut  out  5  registered Rd
- MemtoRegOut, RegWriteOut, BranchTakenOut  out  1 each  registered controls
- FaultOut  out  2  00 none, 01 misaligned, 10 out of range, 11 illegal size
- Busy  out  1  clear sweep in progress

Behaviour:
- Reset (async, active-high):
  - All outputs go to 0, with Busy=1.
  - FSM enters CLEAR and the sweep counter goes to 0.
  - The array is not reset directly.
- FSM states:
  - CLEAR: writes 0 to word[counter] each cycle and increments the counter. After the write to word DEPTH-1, moves to RUN next cycle with Busy=0. Clear takes DEPTH cycles.
  - RUN: normal operation.
  - Reset asserted mid-sweep restarts the sweep at word 0.
- Accept rule: a request is accepted at a rising edge when InValid && Ready. If not accepted, the array and output latch are unchanged, except that OutValid clears when Stall=0.
- Latency: one cycle. A store commits at the accept edge. Load data, pass-through fields and FaultOut are captured in the output latch at that same edge, and OutValid=1 afterwards.
- Stall=1 holds every output register and blocks acceptance.
- Addressing:
  - OFF=log2(XLEN/8) low bits form the byte offset; the next log2(DEPTH) bits form the word index.
  - Range limit: ALUResult >= DEPTH*XLEN/8.
- Fault priority (highest first):
  - Illegal size: Funct3=111, or Funct3 in {011,110} when XLEN=32.
  - Misaligned: offset not a multiple of the access size.
  - Out of range.
- Fault effect: only checked when MemRead or MemWrite is set. On a fault the store is suppressed, ReadDataOut=0, and RegWriteOut is forced to 0. Other fields pass through unchanged.
- Load data:
  - Selected lanes are shifted to bit 0.
  - Signed forms sign-extend from the access MSB; U forms zero-extend.
  - ReadDataOut=0 when MemRead=0.
- Store: only the byte lanes covered by the size and offset are written; other bytes of the word are preserved.
- MemRead and MemWrite both set: treated as a store; ReadDataOut=0.
- Load at edge N+1 to an address stored at edge N returns the new data (no bypass needed; the array is written at the edge).
- BranchTaken, Rd, MemtoReg and ALUResult pass through to the latch unmodified.

Decomposition:
- Package mem_pkg holds:
  - Funct3 size/sign constants
  - fault code constants
  - FSM state encoding (CLEAR, RUN)
  - a function returning the byte count per Funct3
- Sub-module mem_load_align: combinational lane select plus sign/zero extension; inputs are the word, offset and Funct3.
- The store byte-mask generation stays in the top level.

Test Plan:
- Reset, then wait: Busy=1 for exactly 1024 cycles and Ready=0 throughout. Then Busy=0; LD from 0x1FF8 returns 0 with FaultOut=00.
- SD 0xDEADBEEFDEADBEEF at 0x10, then LB at 0x13 returns 0xFFFFFFFFFFFFFFDE, LBU at 0x13 returns 0xDE, LW at 0x14 returns 0xFFFFFFFFDEADBEEF, and LWU at 0x14 returns 0xDEADBEEF.
- SD 0x1122334455667788 at 0x20, then SH 0xABCD at 0x22. LD at 0x20 returns 0x11223344ABCD7788.
- Faults:
  - LW at 0x22 gives FaultOut=01, ReadDataOut=0, RegWriteOut=0.
  - SD at 0x2000 gives FaultOut=10, and a following LD at 0x0 is unchanged.
  - Funct3=111 gives FaultOut=11.
- Hold Stall=1 for 3 cycles with InValid=1 and Rd=13: outputs stay frozen and Ready=0. After release, the request is accepted and RdOut=13 one cycle later.
- Assert reset 500 cycles into the clear sweep: all outputs are 0 immediately. Busy stays 1 for a full 1024 cycles after deassertion.
